// File: rtl/headgen_pipe_s3.sv
`default_nettype none
// ============================================================================
// Module   : headgen_pipe_s3
// Purpose  : Third stage of the header-generation pipeline. Registers the
//            control/tag word and header word from stage 2 and computes the
//            final 16-bit one's-complement checksum from two partial sums.
//            All outputs come straight from flip-flops; latency is 1 clock.
// Ports    : clk        - system clock (rising edge)
//            rst        - asynchronous active-high reset
//            in_0[8:0]  - control/tag word, passed through
//            in_1[15:0] - header word / first checksum partial sum
//            in_2[15:0] - second checksum partial sum
//            enableout  - load enable (1 = capture, 0 = hold)
//            out_0[8:0] - registered in_0
//            out_1[15:0]- registered in_1
//            out_2[15:0]- registered ~(in_1 + in_2, end-around carry)
// Revision : 1.0 - initial release
// ============================================================================
module headgen_pipe_s3 (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  in_0,
  input  logic [15:0] in_1,
  input  logic [15:0] in_2,
  input  logic        enableout,
  output logic [8:0]  out_0,
  output logic [15:0] out_1,
  output logic [15:0] out_2
);

  logic [16:0] w_sum17;
  logic [15:0] w_fold16;
  logic [15:0] csum_d;

  logic [8:0]  tag_q;
  logic [15:0] hdr_q;
  logic [15:0] csum_q;

  // One end-around fold is enough: the largest sum 0x1FFFE folds to 0xFFFF,
  // which cannot carry again.
  always_comb begin
    w_sum17  = {1'b0, in_1} + {1'b0, in_2};
    w_fold16 = w_sum17[15:0] + {15'd0, w_sum17[16]};
    csum_d   = ~w_fold16;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= 9'd0;
      hdr_q  <= 16'd0;
      csum_q <= 16'd0;
    end else if (enableout) begin
      tag_q  <= in_0;
      hdr_q  <= in_1;
      csum_q <= csum_d;
    end
  end

  assign out_0 = tag_q;
  assign out_1 = hdr_q;
  assign out_2 = csum_q;

endmodule
`default_nettype wire

// File: tb/tb_headgen_pipe_s3.sv
`default_nettype none
// ============================================================================
// Module   : tb_headgen_pipe_s3
// Purpose  : Self-checking bench for headgen_pipe_s3. The driver applies
//            directed vectors on the falling edge and queues the output
//            triple expected after the next rising edge; the monitor pops
//            and compares shortly after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_headgen_pipe_s3;

  logic        clk;
  logic        rst;
  logic [8:0]  in_0;
  logic [15:0] in_1;
  logic [15:0] in_2;
  logic        enableout;
  logic [8:0]  out_0;
  logic [15:0] out_1;
  logic [15:0] out_2;

  int checks;
  int errors;

  // Expected output triple {out_0, out_1, out_2}
  logic [40:0] exp_q[$];
  logic [8:0]  m0;
  logic [15:0] m1;
  logic [15:0] m2;

  headgen_pipe_s3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_0      (in_0),
    .in_1      (in_1),
    .in_2      (in_2),
    .enableout (enableout),
    .out_0     (out_0),
    .out_1     (out_1),
    .out_2     (out_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare after each rising edge when an expectation is queued
  always begin
    logic [40:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_0, out_1, out_2} !== e) begin
        errors++;
        $display("FAIL edge_check t=%0t got out_0=%h out_1=%h out_2=%h expected out_0=%h out_1=%h out_2=%h",
                 $time, out_0, out_1, out_2, e[40:32], e[31:16], e[15:0]);
      end
    end
  end

  // Drive one cycle; exp2 is the hand-computed checksum for the vector
  task automatic drive(input logic r, input logic en, input logic [8:0] a,
                       input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] exp2);
    @(negedge clk);
    rst = r; enableout = en; in_0 = a; in_1 = b; in_2 = c;
    if (r) begin
      m0 = '0; m1 = '0; m2 = '0;
    end else if (en) begin
      m0 = a; m1 = b; m2 = exp2;
    end
    exp_q.push_back({m0, m1, m2});
  endtask

  task automatic direct_check(input string name, input logic [40:0] e);
    checks++;
    if ({out_0, out_1, out_2} !== e) begin
      errors++;
      $display("FAIL %s t=%0t got %h/%h/%h expected %h/%h/%h", name, $time,
               out_0, out_1, out_2, e[40:32], e[31:16], e[15:0]);
    end
  endtask

  initial begin
    int wait_cyc;
    checks = 0; errors = 0;
    m0 = '0; m1 = '0; m2 = '0;
    rst = 1'b1; enableout = 1'b0;
    in_0 = 9'h1AB; in_1 = 16'hBEEF; in_2 = 16'h1234;
    #2;
    direct_check("reset_async_initial", 41'd0);

    // Reset pulse with enable low, then held at zero
    drive(1'b1, 1'b0, 9'h1FF, 16'hAAAA, 16'h5555, 16'h0000);
    drive(1'b0, 1'b0, 9'h1FF, 16'hAAAA, 16'h5555, 16'h0000);
    drive(1'b0, 1'b0, 9'h0F0, 16'h1111, 16'h2222, 16'h0000);

    // Load 1, Load 2, carry fold
    drive(1'b0, 1'b1, 9'h155, 16'h0000, 16'h003F, 16'hFFC0);
    drive(1'b0, 1'b1, 9'h155, 16'hFC00, 16'h003F, 16'h03C0);
    drive(1'b0, 1'b1, 9'h000, 16'hFFFF, 16'hFFFF, 16'h0000);
    // Hold with zeroed inputs
    drive(1'b0, 1'b0, 9'h000, 16'h0000, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 9'h000, 16'h0000, 16'h0000, 16'h0000);

    // Boundaries and general patterns
    drive(1'b0, 1'b1, 9'h001, 16'h0000, 16'h0000, 16'hFFFF);
    drive(1'b0, 1'b1, 9'h002, 16'hFFFF, 16'h0001, 16'hFFFE);
    drive(1'b0, 1'b1, 9'h0A5, 16'h1234, 16'h4321, 16'hAAAA);
    drive(1'b0, 1'b1, 9'h15A, 16'h8000, 16'h8000, 16'hFFFE);
    drive(1'b0, 1'b1, 9'h1FF, 16'hF0F0, 16'h0F0F, 16'h0000);
    drive(1'b0, 1'b1, 9'h080, 16'hABCD, 16'h1357, 16'h40DB);

    // Enable glitch between edges must not load
    @(negedge clk);
    enableout = 1'b0; in_0 = 9'h033; in_1 = 16'h7777; in_2 = 16'h0101;
    exp_q.push_back({m0, m1, m2});
    #2 enableout = 1'b1;
    #1 enableout = 1'b0;

    // Asynchronous reset mid-cycle discards the pending load
    drive(1'b0, 1'b1, 9'h0C3, 16'h1000, 16'h0200, 16'hEDFF);
    @(negedge clk);
    enableout = 1'b1; in_0 = 9'h1E1; in_1 = 16'h2222; in_2 = 16'h3333;
    #2 rst = 1'b1;
    #1 direct_check("async_reset", 41'd0);
    m0 = '0; m1 = '0; m2 = '0;
    exp_q.push_back({m0, m1, m2});

    // Release reset with enable low, then first load
    drive(1'b0, 1'b0, 9'h1E1, 16'h2222, 16'h3333, 16'h0000);
    drive(1'b0, 1'b1, 9'h1E1, 16'h2222, 16'h3333, 16'hAAAA);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
